mrd_dft_rdx3_hs: RTL and testbench

Parametrised, flow-controlled radix-3 DFT butterfly for the mixed-radix DFT datapath. Each transfer carries three complex samples and a per-sample direction bit (forward or inverse). The block returns three complex DFT bins on the standard 5-lane bus, with lanes 3 and 4 driven to zero. It adds valid/ready backpressure, a configurable output width, rounded twiddle multiplication and optional saturation. The block sits between the mixed-radix input reorder buffer and the twiddle stage.

---
 rtl/mrd_dft_rdx3_hs.sv | 201 ++++++++++++++++++++
 tb/tb_mrd_dft_rdx3_hs.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mrd_dft_rdx3_hs.sv
// mrd_dft_rdx3_hs: flow-controlled radix-3 DFT butterfly, three registered stages.
// Define MRD_DFT_RDX3_SAT_EN to clamp outputs and drive out_ovf; otherwise outputs wrap.
module mrd_dft_rdx3_hs #(
  parameter int wDataIn  = 30,
  parameter int wDataOut = 30,
  parameter int wCoef    = 18,
  parameter int COEF     = 14189,
  parameter int COEF_Q   = 14
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_val,
  output logic                       in_ready,
  input  logic                       in_inv,
  input  logic signed [wDataIn-1:0]  din_real [0:4],
  input  logic signed [wDataIn-1:0]  din_imag [0:4],
  output logic                       out_val,
  input  logic                       out_ready,
  output logic signed [wDataOut-1:0] dout_real [0:4],
  output logic signed [wDataOut-1:0] dout_imag [0:4],
  output logic                       out_ovf
);
  localparam int WS = wDataIn + 1;
  localparam int WI = wDataIn + 2;
  localparam int WP = wDataIn + 1 + wCoef;
  localparam logic signed [WP-1:0] COEF_P = WP'(COEF);
  localparam logic signed [WP-1:0] RND    = WP'(1) <<< (COEF_Q - 1);

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high. Each stage loads when it is empty or its own content leaves that cycle,
  // so bubbles collapse and in_ready ripples back combinationally from out_ready.
  logic v1, v2, v3, en1, en2, en3;
  assign en3      = !v3 || out_ready;
  assign en2      = !v2 || en3;
  assign en1      = !v1 || en2;
  assign in_ready = en1;
  assign out_val  = v3;

  logic unused_lanes;
  assign unused_lanes = ^{din_real[3], din_real[4], din_imag[3], din_imag[4]};

  // Stage 1: a = x0, s = x1 + x2, d = x2 - x1
  logic                      inv1;
  logic signed [wDataIn-1:0] a1_r, a1_i;
  logic signed [WS-1:0]      s1_r, s1_i, d1_r, d1_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1   <= 1'b0;
      inv1 <= 1'b0;
      a1_r <= '0;
      a1_i <= '0;
      s1_r <= '0;
      s1_i <= '0;
      d1_r <= '0;
      d1_i <= '0;
    end else if (en1) begin
      v1 <= in_val;
      if (in_val) begin
        inv1 <= in_inv;
        a1_r <= din_real[0];
        a1_i <= din_imag[0];
        s1_r <= WS'(din_real[1]) + WS'(din_real[2]);
        s1_i <= WS'(din_imag[1]) + WS'(din_imag[2]);
        d1_r <= WS'(din_real[2]) - WS'(din_real[1]);
        d1_i <= WS'(din_imag[2]) - WS'(din_imag[1]);
      end
    end
  end

  // Stage 2: X0, midpoint m, and p = j*COEF*d
  logic                 inv2;
  logic signed [WI-1:0] x0_2_r, x0_2_i, m2_r, m2_i;
  logic signed [WP-1:0] p2_r, p2_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      v2     <= 1'b0;
      inv2   <= 1'b0;
      x0_2_r <= '0;
      x0_2_i <= '0;
      m2_r   <= '0;
      m2_i   <= '0;
      p2_r   <= '0;
      p2_i   <= '0;
    end else if (en2) begin
      v2 <= v1;
      if (v1) begin
        inv2   <= inv1;
        x0_2_r <= WI'(a1_r) + WI'(s1_r);
        x0_2_i <= WI'(a1_i) + WI'(s1_i);
        m2_r   <= WI'(a1_r) - WI'(s1_r >>> 1);
        m2_i   <= WI'(a1_i) - WI'(s1_i >>> 1);
        p2_r   <= -(COEF_P * WP'(d1_i));
        p2_i   <= COEF_P * WP'(d1_r);
      end
    end
  end

  // Stage 3: round the twiddle product, combine, reduce to the output width
  logic signed [WP-1:0]       tw_r, tw_i;
  logic signed [WI-1:0]       t_r, t_i;
  logic signed [WI-1:0]       yc_r [0:2];
  logic signed [WI-1:0]       yc_i [0:2];
  logic signed [wDataOut-1:0] yo_r [0:2];
  logic signed [wDataOut-1:0] yo_i [0:2];

`ifdef MRD_DFT_RDX3_SAT_EN
  localparam int WX = ((wDataOut > WI) ? wDataOut : WI) + 1;
  localparam logic signed [WX-1:0] O_MAX = {{(WX-wDataOut+1){1'b0}}, {(wDataOut-1){1'b1}}};
  localparam logic signed [WX-1:0] O_MIN = {{(WX-wDataOut+1){1'b1}}, {(wDataOut-1){1'b0}}};
  logic [5:0] clip;
  logic       ovf3;

  // Returns {clipped, value}.
  function automatic logic [wDataOut:0] fit(input logic signed [WI-1:0] v);
    logic signed [WX-1:0] vx;
    vx = WX'(v);
    if (vx > O_MAX)      fit = {1'b1, O_MAX[wDataOut-1:0]};
    else if (vx < O_MIN) fit = {1'b1, O_MIN[wDataOut-1:0]};
    else                 fit = {1'b0, vx[wDataOut-1:0]};
  endfunction
`endif

  always_comb begin
    tw_r    = (p2_r + RND) >>> COEF_Q;
    tw_i    = (p2_i + RND) >>> COEF_Q;
    t_r     = WI'(tw_r);
    t_i     = WI'(tw_i);
    yc_r[0] = x0_2_r;
    yc_i[0] = x0_2_i;
    if (inv2) begin
      yc_r[1] = m2_r - t_r;
      yc_i[1] = m2_i - t_i;
      yc_r[2] = m2_r + t_r;
      yc_i[2] = m2_i + t_i;
    end else begin
      yc_r[1] = m2_r + t_r;
      yc_i[1] = m2_i + t_i;
      yc_r[2] = m2_r - t_r;
      yc_i[2] = m2_i - t_i;
    end
`ifdef MRD_DFT_RDX3_SAT_EN
    clip = '0;
    for (int k = 0; k < 3; k++) begin
      {clip[2*k], yo_r[k]}   = fit(yc_r[k]);
      {clip[2*k+1], yo_i[k]} = fit(yc_i[k]);
    end
`else
    for (int k = 0; k < 3; k++) begin
      yo_r[k] = wDataOut'(yc_r[k]);
      yo_i[k] = wDataOut'(yc_i[k]);
    end
`endif
  end

  logic signed [wDataOut-1:0] y3_r [0:2];
  logic signed [wDataOut-1:0] y3_i [0:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      v3 <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        y3_r[k] <= '0;
        y3_i[k] <= '0;
      end
`ifdef MRD_DFT_RDX3_SAT_EN
      ovf3 <= 1'b0;
`endif
    end else if (en3) begin
      v3 <= v2;
      if (v2) begin
        for (int k = 0; k < 3; k++) begin
          y3_r[k] <= yo_r[k];
          y3_i[k] <= yo_i[k];
        end
`ifdef MRD_DFT_RDX3_SAT_EN
        ovf3 <= |clip;
`endif
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 5; k++) begin
      dout_real[k] = '0;
      dout_imag[k] = '0;
    end
    for (int k = 0; k < 3; k++) begin
      dout_real[k] = y3_r[k];
      dout_imag[k] = y3_i[k];
    end
  end

`ifdef MRD_DFT_RDX3_SAT_EN
  assign out_ovf = ovf3;
`else
  assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_mrd_dft_rdx3_hs.sv
// tb_mrd_dft_rdx3_hs: scoreboard bench for the radix-3 butterfly, default widths
// plus a 16-bit instance for the overflow case.
module tb_mrd_dft_rdx3_hs;
  localparam int WI   = 30;
  localparam int WO   = 30;
  localparam int WC   = 18;
  localparam int COEF = 14189;
  localparam int CQ   = 14;
  localparam int EW   = 10 * WO + 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  initial forever #5 clk = ~clk;

  logic                 in_val, in_ready, in_inv, out_val, out_ready, out_ovf;
  logic signed [WI-1:0] din_real [0:4];
  logic signed [WI-1:0] din_imag [0:4];
  logic signed [WO-1:0] dout_real [0:4];
  logic signed [WO-1:0] dout_imag [0:4];

  logic              in_val16, in_ready16, in_inv16, out_val16, out_ready16, out_ovf16;
  logic signed [15:0] din16_real [0:4];
  logic signed [15:0] din16_imag [0:4];
  logic signed [15:0] dout16_real [0:4];
  logic signed [15:0] dout16_imag [0:4];

  mrd_dft_rdx3_hs #(.wDataIn(WI), .wDataOut(WO), .wCoef(WC), .COEF(COEF), .COEF_Q(CQ)) dut (
    .clk(clk), .rst(rst), .in_val(in_val), .in_ready(in_ready), .in_inv(in_inv),
    .din_real(din_real), .din_imag(din_imag), .out_val(out_val), .out_ready(out_ready),
    .dout_real(dout_real), .dout_imag(dout_imag), .out_ovf(out_ovf));

  mrd_dft_rdx3_hs #(.wDataIn(16), .wDataOut(16), .wCoef(WC), .COEF(COEF), .COEF_Q(CQ)) dut16 (
    .clk(clk), .rst(rst), .in_val(in_val16), .in_ready(in_ready16), .in_inv(in_inv16),
    .din_real(din16_real), .din_imag(din16_imag), .out_val(out_val16), .out_ready(out_ready16),
    .dout_real(dout16_real), .dout_imag(dout16_imag), .out_ovf(out_ovf16));

  int              total = 0;
  int              bad = 0;
  int              n_acc = 0;
  int              rdy_mode = 0;
  longint          cyc = 0;
  longint          fire_cyc = 0;
  logic [EW-1:0]   exp_q[$];
  bit              held = 1'b0;
  logic [EW-1:0]   held_vec;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // reference model: three-point DFT, X_k = sum x_n * W^(nk), W = e^(-+j*2pi/3)
  function automatic longint fit_ref(input longint v, input int wo, inout bit ovf);
`ifdef MRD_DFT_RDX3_SAT_EN
    longint hi, lo;
    hi = (longint'(1) <<< (wo - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) begin ovf = 1'b1; return hi; end
    if (v < lo) begin ovf = 1'b1; return lo; end
    return v;
`else
    return (v <<< (64 - wo)) >>> (64 - wo);
`endif
  endfunction

  function automatic void dft3(input longint xr[3], input longint xi[3], input bit inv,
                               input int wo, output longint yr[3], output longint yi[3],
                               output bit ovf);
    longint sr, si, dr, di, mr, mi, tr, ti, sg;
    ovf = 1'b0;
    sr = xr[1] + xr[2];
    si = xi[1] + xi[2];
    dr = xr[2] - xr[1];
    di = xi[2] - xi[1];
    // -1/2 of the pair sum, floor division by two
    mr = xr[0] - (sr >>> 1);
    mi = xi[0] - (si >>> 1);
    // j * sin(60) * d, rounded half up in Q14
    tr = (-longint'(COEF) * di + (longint'(1) <<< (CQ - 1))) >>> CQ;
    ti = (longint'(COEF) * dr + (longint'(1) <<< (CQ - 1))) >>> CQ;
    sg = inv ? -1 : 1;
    yr[0] = fit_ref(xr[0] + sr, wo, ovf);
    yi[0] = fit_ref(xi[0] + si, wo, ovf);
    yr[1] = fit_ref(mr + sg * tr, wo, ovf);
    yi[1] = fit_ref(mi + sg * ti, wo, ovf);
    yr[2] = fit_ref(mr - sg * tr, wo, ovf);
    yi[2] = fit_ref(mi - sg * ti, wo, ovf);
  endfunction

  function automatic logic [EW-1:0] pack(input longint yr[3], input longint yi[3], input bit ovf);
    logic [EW-1:0] v;
    v = '0;
    for (int k = 0; k < 3; k++) begin
      v[k*2*WO +: WO]      = yr[k][WO-1:0];
      v[k*2*WO + WO +: WO] = yi[k][WO-1:0];
    end
    v[EW-1] = ovf;
    return v;
  endfunction

  function automatic longint dout_nz();
    logic a;
    a = out_ovf;
    for (int k = 0; k < 5; k++) a = a | (|dout_real[k]) | (|dout_imag[k]);
    return longint'(a);
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic longint rnd();
    logic signed [WI-1:0] r;
    r = WI'($urandom);
    if ($urandom_range(0, 1) == 0) r = r >>> 14;
    if ($urandom_range(0, 7) == 0) r = {1'b0, {(WI-1){1'b1}}};
    if ($urandom_range(0, 7) == 0) r = {1'b1, {(WI-1){1'b0}}};
    return longint'(r);
  endfunction

  task automatic set_rdy(input int m);
    rdy_mode  = m;
    out_ready = (m != 2);
  endtask

  // driver: present one sample, hold until accepted, push its expected result
  task automatic send(input longint r0, input longint i0, input longint r1, input longint i1,
                      input longint r2, input longint i2, input bit inv);
    longint xr[3], xi[3], yr[3], yi[3];
    bit ov, done;
    xr[0] = r0; xr[1] = r1; xr[2] = r2;
    xi[0] = i0; xi[1] = i1; xi[2] = i2;
    done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      din_real[k] = WI'(xr[k]);
      din_imag[k] = WI'(xi[k]);
    end
    for (int k = 3; k < 5; k++) begin
      din_real[k] = WI'($urandom);
      din_imag[k] = WI'($urandom);
    end
    in_inv = inv;
    in_val = 1'b1;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (in_ready) begin
        dft3(xr, xi, inv, WO, yr, yi, ov);
        exp_q.push_back(pack(yr, yi, ov));
        n_acc++;
        fire_cyc = cyc;
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_val = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready got 0 expected 1");
    end
  endtask

  task automatic drain();
    int c;
    c = 0;
    do begin
      @(posedge clk);
      #1;
      c++;
    end while (exp_q.size() != 0 && c < 200);
    chk("drain_pending", exp_q.size(), 0);
  endtask

  task automatic wait_out(input string nm);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!out_val && c < 20);
    chk(nm, cyc - fire_cyc, 3);
    @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  // monitor / scoreboard
  initial forever begin
    logic [EW-1:0] act, e;
    @(negedge clk);
    if (rst) begin
      held = 1'b0;
    end else begin
      act = '0;
      for (int k = 0; k < 5; k++) begin
        act[k*2*WO +: WO]      = dout_real[k];
        act[k*2*WO + WO +: WO] = dout_imag[k];
      end
      act[EW-1] = out_ovf;
      if (held) begin
        total++;
        if (!out_val || act !== held_vec) begin
          bad++;
          $display("FAIL stall_hold: got val=%0b %h expected val=1 %h", out_val, act, held_vec);
        end
      end
      if (out_val && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_out: got %h expected no output", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            bad++;
            $display("FAIL dout: got %h expected %h", act, e);
          end
        end
      end
      held     = out_val && !out_ready;
      held_vec = act;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    longint dcyc, xr16[3], xi16[3], yr16[3], yi16[3];
    bit ov16;
    int base;
    rst = 1'b1;
    in_val = 1'b0; in_inv = 1'b0; out_ready = 1'b1;
    in_val16 = 1'b0; in_inv16 = 1'b0; out_ready16 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      din_real[k] = '0; din_imag[k] = '0;
      din16_real[k] = '0; din16_imag[k] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_val", out_val, 0);
    chk("reset_dout", dout_nz(), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    dcyc = cyc;

    // DC impulse accepted in the deassert cycle, 3-cycle latency
    send(100, 0, 0, 0, 0, 0, 1'b0);
    chk("accept_on_deassert", fire_cyc, dcyc);
    wait_out("dc_latency");

    // single tone forward / inverse, alternating back to back, rounding case
    send(0, 0, 1000, 0, 0, 0, 1'b0);
    send(0, 0, 1000, 0, 0, 0, 1'b1);
    send(0, 0, 1000, 0, 0, 0, 1'b0);
    send(0, 0, 1000, 0, 0, 0, 1'b1);
    send(0, 0, 0, 0, 1, 0, 1'b0);
    drain();

    // randomized traffic with random backpressure
    set_rdy(1);
    for (int n = 0; n < 300; n++) begin
      send(rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    set_rdy(0);
    drain();

    // backpressure: out_ready low for 5 cycles under continuous input
    set_rdy(2);
    base = n_acc;
    fork
      begin
        for (int i = 0; i < 8; i++) send(longint'(200 + i), 0, 0, 0, 0, 0, 1'b0);
      end
      begin
        int c;
        c = 0;
        while (n_acc < base + 3 && c < 50) begin
          @(posedge clk);
          c++;
        end
        @(negedge clk);
        chk("bp_in_ready_full", in_ready, 0);
        chk("bp_out_val_stalled", out_val, 1);
        repeat (2) @(posedge clk);
        #1;
        set_rdy(0);
      end
    join
    drain();

    // reset with two samples in flight, in_val high during reset
    send(1, 2, 3, 4, 5, 6, 1'b0);
    send(7, 8, 9, 10, 11, 12, 1'b1);
    rst = 1'b1;
    in_val = 1'b1;
    din_real[0] = WI'(555);
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_val = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("mid_rst_out_val", out_val, 0);
    chk("mid_rst_dout", dout_nz(), 0);
    chk("mid_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    send(42, -7, 0, 0, 0, 0, 1'b0);
    wait_out("post_rst_latency");
    drain();

    // overflow on the 16-bit instance
    for (int k = 0; k < 3; k++) begin
      din16_real[k] = 16'sd32767;
      xr16[k] = 32767;
      xi16[k] = 0;
    end
    in_val16 = 1'b1;
    @(posedge clk);
    #1;
    in_val16 = 1'b0;
    for (int c = 0; c < 20 && !out_val16; c++) @(negedge clk);
    dft3(xr16, xi16, 1'b0, 16, yr16, yi16, ov16);
`ifdef MRD_DFT_RDX3_SAT_EN
    chk("ovf16_x0_real", dout16_real[0], 32767);
    chk("ovf16_flag", out_ovf16, 1);
`else
    chk("ovf16_x0_real", dout16_real[0], 32765);
    chk("ovf16_flag", out_ovf16, 0);
`endif
    chk("ovf16_x1_real", dout16_real[1], yr16[1]);
    chk("ovf16_x2_imag", dout16_imag[2], yi16[2]);
    chk("ovf16_in_ready", in_ready16, 1);
    chk("ovf16_model_flag", out_ovf16, ov16);

    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
